// File: rtl/sdram_rw_arbiter_if.sv
// Requester-side and SDRAM-wrapper-side signals of the SDRAM burst arbiter.
// slave = arbiter view, master = environment (requesters + wrapper) view.
interface sdram_rw_arbiter_if #(
    parameter int N_REQ = 3
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ-1:0]       req_wr;
    logic [32*N_REQ-1:0]    req_addr;
    logic [11*N_REQ-1:0]    req_cnt;
    logic [128*N_REQ-1:0]   req_wdata;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       done;
    logic [127:0]           rd_data;
    logic [N_REQ-1:0]       rd_valid;
    logic [N_REQ-1:0]       wr_nxt;
    logic                   busy;

    logic [31:0]            sd_rw_addr;
    logic [10:0]            sd_rw_cnt;
    logic                   sd_rw_done;
    logic                   sd_read_start;
    logic [127:0]           sd_read_data;
    logic                   sd_read_valid;
    logic                   sd_write_start;
    logic [127:0]           sd_write_data;
    logic                   sd_write_nxt;

    modport slave (
        input  req, req_wr, req_addr, req_cnt, req_wdata,
        output grant, done, rd_data, rd_valid, wr_nxt, busy,
        output sd_rw_addr, sd_rw_cnt, sd_read_start, sd_write_start, sd_write_data,
        input  sd_rw_done, sd_read_data, sd_read_valid, sd_write_nxt
    );

    modport master (
        output req, req_wr, req_addr, req_cnt, req_wdata,
        input  grant, done, rd_data, rd_valid, wr_nxt, busy,
        input  sd_rw_addr, sd_rw_cnt, sd_read_start, sd_write_start, sd_write_data,
        output sd_rw_done, sd_read_data, sd_read_valid, sd_write_nxt
    );
endinterface

// File: rtl/sdram_rw_arbiter.sv
// Round-robin arbiter sharing one SDRAM burst-master port between N_REQ requesters.
// Latency: start pulse in the cycle after req is seen in IDLE; done 1 cycle after rw_done.
// Backpressure: one burst at a time, req held until done; SDRAM_ARB_WATCHDOG_EN adds err + stall watchdog.
module sdram_rw_arbiter #(
    parameter int N_REQ       = 3,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sdram_rw_arbiter_if.slave    bus
`ifdef SDRAM_ARB_WATCHDOG_EN
    ,
    output logic                 err
`endif
);
    localparam int IW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_param
        $error("sdram_rw_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, FIN} state_t;

    state_t             state;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      gidx;
    logic               lat_wr;
    logic [31:0]        rw_addr;
    logic [10:0]        rw_cnt;
    logic [N_REQ-1:0]   grant_q;
    logic [N_REQ-1:0]   done_q;
    logic               rd_start_q;
    logic               wr_start_q;

    logic               sel_vld;
    logic [IW-1:0]      sel_idx;
    logic [IW-1:0]      cand;
    logic [10:0]        sel_cnt;
    logic               sel_wr;

    // First requester at or after ptr, wrapping: scan downward so the lowest offset wins.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr) + k) % N_REQ);
            if (bus.req[cand]) begin
                sel_vld = 1'b1;
                sel_idx = cand;
            end
        end
    end

    assign sel_cnt = bus.req_cnt[11*sel_idx +: 11];
    assign sel_wr  = bus.req_wr[sel_idx];

`ifdef SDRAM_ARB_WATCHDOG_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] wd_cnt;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ptr        <= '0;
            gidx       <= '0;
            lat_wr     <= 1'b0;
            rw_addr    <= '0;
            rw_cnt     <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            rd_start_q <= 1'b0;
            wr_start_q <= 1'b0;
`ifdef SDRAM_ARB_WATCHDOG_EN
            wd_cnt     <= '0;
            err        <= 1'b0;
`endif
        end else begin
            done_q     <= '0;
            rd_start_q <= 1'b0;
            wr_start_q <= 1'b0;
`ifdef SDRAM_ARB_WATCHDOG_EN
            err        <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        gidx    <= sel_idx;
                        lat_wr  <= sel_wr;
                        grant_q <= N_REQ'(1) << sel_idx;
                        // Zero-length bursts never reach the wrapper, so its address/count stay put.
                        if (sel_cnt == 11'd0) begin
                            done_q <= N_REQ'(1) << sel_idx;
                            state  <= FIN;
                        end else begin
                            rw_addr    <= bus.req_addr[32*sel_idx +: 32];
                            rw_cnt     <= sel_cnt;
                            rd_start_q <= ~sel_wr;
                            wr_start_q <= sel_wr;
                            state      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
`ifdef SDRAM_ARB_WATCHDOG_EN
                    wd_cnt <= '0;
`endif
                    state  <= BUSY;
                end
                BUSY: begin
                    if (bus.sd_rw_done) begin
                        done_q <= grant_q;
                        state  <= FIN;
                    end
`ifdef SDRAM_ARB_WATCHDOG_EN
                    else if (bus.sd_read_valid || bus.sd_write_nxt) begin
                        wd_cnt <= '0;
                    end else if (wd_cnt == WD_LAST) begin
                        done_q <= grant_q;
                        err    <= 1'b1;
                        state  <= FIN;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
`endif
                end
                FIN: begin
                    grant_q <= '0;
                    ptr     <= (gidx == IW'(N_REQ - 1)) ? '0 : gidx + IW'(1);
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant          = grant_q;
    assign bus.done           = done_q;
    assign bus.busy           = (state != IDLE);
    assign bus.sd_rw_addr     = rw_addr;
    assign bus.sd_rw_cnt      = rw_cnt;
    assign bus.sd_read_start  = rd_start_q;
    assign bus.sd_write_start = wr_start_q;

    // Beat handshakes are only meaningful while the wrapper owns the burst.
    assign bus.rd_data       = bus.sd_read_data;
    assign bus.rd_valid      = (state == BUSY && !lat_wr && bus.sd_read_valid) ? grant_q : '0;
    assign bus.wr_nxt        = (state == BUSY &&  lat_wr && bus.sd_write_nxt)  ? grant_q : '0;
    assign bus.sd_write_data = (|grant_q) ? bus.req_wdata[128*gidx +: 128] : '0;
endmodule

// File: tb/tb_sdram_rw_arbiter.sv
// Bench for sdram_rw_arbiter: bench plays requesters and SDRAM wrapper, checks against a round-robin model.
module tb_sdram_rw_arbiter;
    localparam int N  = 3;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sdram_rw_arbiter_if #(.N_REQ(N)) bus ();
`ifdef SDRAM_ARB_WATCHDOG_EN
    logic err;
`endif

    sdram_rw_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef SDRAM_ARB_WATCHDOG_EN
        ,
        .err     (err)
`endif
    );

    int          errors = 0;
    int          checks = 0;
    int          ptr_m = 0;
    logic [31:0] last_addr = '0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (r[j +: 1] == 1'b1) return j;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic on, input logic wr, input logic [31:0] a,
                           input logic [10:0] c, input logic [127:0] d);
        bus.req[i +: 1]          = on;
        bus.req_wr[i +: 1]       = wr;
        bus.req_addr[32*i +: 32] = a;
        bus.req_cnt[11*i +: 11]  = c;
        bus.req_wdata[128*i +: 128] = d;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_grant"}, 128'(bus.grant), 128'(0));
        chk({tag, "_done"},  128'(bus.done), 128'(0));
        chk({tag, "_busy"},  128'(bus.busy), 128'(0));
        chk({tag, "_wdata"}, bus.sd_write_data, 128'(0));
    endtask

    // One complete arbitration + burst from the IDLE state, wrapper behaviour randomized.
    task automatic run_one(input bit allow_drop, output int w, output logic [N-1:0] g_obs);
        logic [N-1:0]  oh;
        logic [127:0]  d;
        logic [127:0]  wd;
        logic          wr;
        int            c;
        w = pick(bus.req, ptr_m);
        if (w < 0) begin
            chk("model_no_request", 128'(0), 128'(1));
            g_obs = '0;
            return;
        end
        oh = N'(1) << w;
        wr = bus.req_wr[w +: 1];
        c  = int'(bus.req_cnt[11*w +: 11]);
        wd = bus.req_wdata[128*w +: 128];
        tick;
        g_obs = bus.grant;
        chk("grant", 128'(bus.grant), 128'(oh));
        chk("busy_on", 128'(bus.busy), 128'(1));
        if (c == 0) begin
            chk("zc_done", 128'(bus.done), 128'(oh));
            chk("zc_starts", 128'({bus.sd_read_start, bus.sd_write_start}), 128'(0));
            chk("zc_addr", 128'(bus.sd_rw_addr), 128'(last_addr));
        end else begin
            chk("rd_start", 128'(bus.sd_read_start), 128'(!wr));
            chk("wr_start", 128'(bus.sd_write_start), 128'(wr));
            chk("rw_addr", 128'(bus.sd_rw_addr), 128'(bus.req_addr[32*w +: 32]));
            chk("rw_cnt", 128'(bus.sd_rw_cnt), 128'(c));
            chk("wdata_issue", bus.sd_write_data, wd);
            last_addr = bus.req_addr[32*w +: 32];
            bus.sd_read_valid = 1'b1;
            bus.sd_write_nxt  = 1'b1;
            #1;
            chk("stray_issue", 128'({bus.rd_valid, bus.wr_nxt}), 128'(0));
            bus.sd_read_valid = 1'b0;
            bus.sd_write_nxt  = 1'b0;
            tick;
            chk("start_one_cycle", 128'({bus.sd_read_start, bus.sd_write_start}), 128'(0));
            if (allow_drop && $urandom_range(0, 3) == 0) bus.req[w +: 1] = 1'b0;
            for (int b = 0; b < c; b++) begin
                repeat ($urandom_range(0, 2)) tick;
                d = {$urandom, $urandom, $urandom, $urandom};
                bus.sd_read_data = d;
                if (wr) bus.sd_write_nxt = 1'b1;
                else    bus.sd_read_valid = 1'b1;
                #1;
                chk("rd_valid", 128'(bus.rd_valid), wr ? 128'(0) : 128'(oh));
                chk("wr_nxt", 128'(bus.wr_nxt), wr ? 128'(oh) : 128'(0));
                if (wr) chk("wdata_beat", bus.sd_write_data, wd);
                else    chk("rd_data", bus.rd_data, d);
                tick;
                bus.sd_read_valid = 1'b0;
                bus.sd_write_nxt  = 1'b0;
            end
            bus.sd_rw_done = 1'b1;
            tick;
            bus.sd_rw_done = 1'b0;
            chk("done", 128'(bus.done), 128'(oh));
            chk("grant_fin", 128'(bus.grant), 128'(oh));
`ifdef SDRAM_ARB_WATCHDOG_EN
            chk("err_normal", 128'(err), 128'(0));
`endif
            bus.sd_read_valid = 1'b1;
            bus.sd_write_nxt  = 1'b1;
            #1;
            chk("stray_fin", 128'({bus.rd_valid, bus.wr_nxt}), 128'(0));
            bus.sd_read_valid = 1'b0;
            bus.sd_write_nxt  = 1'b0;
        end
        tick;
        chk_idle("after");
        ptr_m = (w + 1) % N;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int            w;
        int            nd;
        logic [N-1:0]  g;
        logic [N-1:0]  rr_exp [4];
        rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;

        bus.req = '0; bus.req_wr = '0; bus.req_addr = '0; bus.req_cnt = '0; bus.req_wdata = '0;
        bus.sd_rw_done = 1'b0; bus.sd_read_data = '0; bus.sd_read_valid = 1'b0; bus.sd_write_nxt = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        chk("reset_addr", 128'(bus.sd_rw_addr), 128'(0));
        chk("reset_cnt", 128'(bus.sd_rw_cnt), 128'(0));
        chk("reset_starts", 128'({bus.sd_read_start, bus.sd_write_start}), 128'(0));
        chk("reset_steer", 128'({bus.rd_valid, bus.wr_nxt}), 128'(0));
`ifdef SDRAM_ARB_WATCHDOG_EN
        chk("reset_err", 128'(err), 128'(0));
`endif
        reset_n = 1'b1;

        // All three requesting continuously, one-beat bursts.
        for (int i = 0; i < N; i++)
            set_req(i, 1'b1, 1'($urandom_range(0, 1)), 32'h1000_0000 + 32'(i * 64), 11'd1, {4{$urandom}});
        for (int n = 0; n < 4; n++) begin
            run_one(1'b0, w, g);
            chk("rr_order", 128'(g), 128'(rr_exp[n]));
        end
        bus.req = '0;

        // Single read from requester 0.
        set_req(0, 1'b1, 1'b0, 32'h3000_0000, 11'd4, '0);
        run_one(1'b0, w, g);
        chk("single_rd_grant", 128'(g), 128'(3'b001));
        chk("single_rd_addr", 128'(bus.sd_rw_addr), 128'(32'h3000_0000));
        bus.req = '0;

        // Write steering from requester 2 with distinct data on every port.
        set_req(0, 1'b0, 1'b1, 32'h0, 11'd3, {4{32'hAAAA_0000}});
        set_req(1, 1'b0, 1'b1, 32'h0, 11'd3, {4{32'hBBBB_1111}});
        set_req(2, 1'b1, 1'b1, 32'h4000_0100, 11'd3, {4{32'hCCCC_2222}});
        run_one(1'b0, w, g);
        chk("write_grant", 128'(g), 128'(3'b100));
        bus.req = '0;

        // Zero-length burst from requester 1.
        set_req(1, 1'b1, 1'b0, 32'h5555_0000, 11'd0, '0);
        run_one(1'b0, w, g);
        chk("zero_addr_kept", 128'(bus.sd_rw_addr), 128'(32'h4000_0100));
        bus.req = '0;

        // Randomized traffic, including requests dropped mid-burst.
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < N; i++)
                set_req(i, 1'b0, 1'($urandom_range(0, 1)), $urandom, 11'($urandom_range(0, 4)), {4{$urandom}});
            bus.req = N'($urandom_range(1, (1 << N) - 1));
            run_one(1'b1, w, g);
        end
        bus.req = '0;

`ifdef SDRAM_ARB_WATCHDOG_EN
        // Silent wrapper: watchdog must terminate the burst.
        set_req(0, 1'b1, 1'b0, 32'h6000_0000, 11'd4, '0);
        w = pick(bus.req, ptr_m);
        tick;
        tick;
        nd = -1;
        g = '0;
        for (int k = 1; k <= 20 && nd < 0; k++) begin
            tick;
            if (bus.done != '0) begin
                nd = k;
                g = bus.done;
                chk("wd_err", 128'(err), 128'(1));
            end
        end
        chk("wd_latency", 128'(nd), 128'(TO));
        chk("wd_done", 128'(g), 128'(3'b001));
        tick;
        chk("wd_err_clr", 128'(err), 128'(0));
        chk_idle("wd_after");
        ptr_m = (w + 1) % N;
        bus.req = '0;
`endif

        // Move the pointer past 0, then reset in the middle of a burst from requester 1.
        set_req(0, 1'b1, 1'b0, 32'h7000_0000, 11'd2, '0);
        run_one(1'b0, w, g);
        bus.req = '0;
        set_req(1, 1'b1, 1'b0, 32'h7100_0000, 11'd4, '0);
        tick;
        chk("pre_rst_grant", 128'(bus.grant), 128'(3'b010));
        tick;
        nd = 0;
`ifdef SDRAM_ARB_WATCHDOG_EN
        repeat (3) tick;
`else
        for (int k = 0; k < 40; k++) begin
            tick;
            if (bus.done != '0) nd++;
        end
        chk("stall_no_done", 128'(nd), 128'(0));
        chk("stall_busy", 128'(bus.busy), 128'(1));
`endif
        bus.req[0 +: 1] = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        chk_idle("midrst");
        chk("midrst_addr", 128'(bus.sd_rw_addr), 128'(0));
        chk("midrst_cnt", 128'(bus.sd_rw_cnt), 128'(0));
        chk("midrst_starts", 128'({bus.sd_read_start, bus.sd_write_start}), 128'(0));
`ifdef SDRAM_ARB_WATCHDOG_EN
        chk("midrst_err", 128'(err), 128'(0));
`endif
        tick;
        tick;
        reset_n = 1'b1;
        ptr_m = 0;
        last_addr = '0;
        run_one(1'b0, w, g);
        chk("post_rst_grant", 128'(g), 128'(3'b001));
        bus.req = '0;
        tick;
        chk_idle("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
